// File: rtl/eth_rx_filter_pkg.sv
// Shared Ethernet L2 constants, FSM encoding and beat payload for the RX header filter.
package eth_rx_filter_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAC_W     = 48;
    localparam int unsigned ETYPE_W   = 16;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned HDR_WORDS = 4;
    localparam int unsigned HDR_IDX_W = 2;

    localparam logic [ETYPE_W-1:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [ETYPE_W-1:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [MAC_W-1:0]   ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    // Header word slots: w0={16'h0,dst_hi}, w1=dst_lo, w2=src_hi, w3={src_lo,etype}
    localparam logic [HDR_IDX_W-1:0] HDR_W0 = 2'd0;
    localparam logic [HDR_IDX_W-1:0] HDR_W1 = 2'd1;
    localparam logic [HDR_IDX_W-1:0] HDR_W2 = 2'd2;
    localparam logic [HDR_IDX_W-1:0] HDR_W3 = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        REPLAY = 3'd2,
        PASS   = 3'd3,
        DROP   = 3'd4
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } eth_beat_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/eth_hdr_buf.sv
// 4x32 L2 header register file: write index with restart, eop-on-w3 flag, replay read index.
module eth_hdr_buf
    import eth_rx_filter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic                 wr_restart_i,
    input  logic [DATA_W-1:0]    wr_data_i,
    input  logic                 wr_eop_i,
    output logic [HDR_IDX_W-1:0] wr_idx_o,
    output logic [MAC_W-1:0]     dst_o,
    input  logic                 rd_adv_i,
    output logic [HDR_IDX_W-1:0] rd_idx_o,
    output logic [DATA_W-1:0]    rd_data_o,
    output logic                 eop_flag_o
);

    logic [HDR_WORDS-1:0][DATA_W-1:0] mem_q;
    logic [HDR_IDX_W-1:0]             wr_idx_q;
    logic [HDR_IDX_W-1:0]             rd_idx_q;
    logic                             eop_q;
    logic [HDR_IDX_W-1:0]             wr_ptr;

    // A restart (sop) always lands in slot 0 regardless of the running index
    assign wr_ptr = wr_restart_i ? HDR_W0 : wr_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_idx_q <= HDR_W0;
            rd_idx_q <= HDR_W0;
            eop_q    <= 1'b0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr] <= wr_data_i;
                wr_idx_q      <= wr_ptr + HDR_IDX_W'(1);
                if (wr_ptr == HDR_W3) begin
                    eop_q <= wr_eop_i;
                end
            end
            if (wr_en_i && wr_restart_i) begin
                rd_idx_q <= HDR_W0;
            end else if (rd_adv_i) begin
                rd_idx_q <= rd_idx_q + HDR_IDX_W'(1);
            end
        end
    end

    assign wr_idx_o   = wr_idx_q;
    assign rd_idx_o   = rd_idx_q;
    assign rd_data_o  = mem_q[rd_idx_q];
    assign eop_flag_o = eop_q;
    assign dst_o      = {mem_q[HDR_W0][15:0], mem_q[HDR_W1]};

endmodule

// File: rtl/eth_rx_filter.sv
// Ingress L2 filter: forwards own-MAC/broadcast ARP/IPv4 frames, drops the rest.
// Optional saturating frame counters are built when ETH_RX_FILTER_STATS_EN is defined.
module eth_rx_filter
    import eth_rx_filter_pkg::*;
#(
    parameter bit                 ACCEPT_BCAST = 1'b1,
    parameter logic [ETYPE_W-1:0] ETYPE_A      = ETH_TYPE_ARP,
    parameter logic [ETYPE_W-1:0] ETYPE_B      = ETH_TYPE_IPV4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MAC_W-1:0]    i_self_mac,
    input  logic [DATA_W-1:0]   i_rx_data,
    input  logic                i_rx_sop,
    input  logic                i_rx_eop,
    input  logic                i_rx_vld,
    output logic                o_rx_rdy,
    output logic [DATA_W-1:0]   o_tx_data,
    output logic                o_tx_sop,
    output logic                o_tx_eop,
    output logic                o_tx_vld,
    input  logic                i_tx_rdy,
`ifdef ETH_RX_FILTER_STATS_EN
    output logic [CNT_W-1:0]    o_cnt_acc,
    output logic [CNT_W-1:0]    o_cnt_drop,
    output logic [CNT_W-1:0]    o_cnt_runt,
`endif
    output logic                o_frm_drop
);

    state_e               state_q, state_d;
    eth_beat_t            rx_beat;
    logic                 in_xfer;
    logic                 live_q;
    logic                 frm_drop_q;
    logic                 drop_c, runt_c;
    logic                 buf_wr, buf_restart, rd_adv;
    logic [HDR_IDX_W-1:0] wr_idx, rd_idx;
    logic [DATA_W-1:0]    rd_data;
    logic                 eop_flag;
    logic [MAC_W-1:0]     dst;
    logic [ETYPE_W-1:0]   etype;
    logic                 dst_hit, type_hit, accept;

    assign rx_beat = '{data: i_rx_data, sop: i_rx_sop, eop: i_rx_eop};
    assign in_xfer = i_rx_vld && o_rx_rdy;

    eth_hdr_buf u_hdr_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (buf_wr),
        .wr_restart_i (buf_restart),
        .wr_data_i    (rx_beat.data),
        .wr_eop_i     (rx_beat.eop),
        .wr_idx_o     (wr_idx),
        .dst_o        (dst),
        .rd_adv_i     (rd_adv),
        .rd_idx_o     (rd_idx),
        .rd_data_o    (rd_data),
        .eop_flag_o   (eop_flag)
    );

    // Filter verdict, evaluated against w3 while it is on the ingress bus
    assign etype    = rx_beat.data[ETYPE_W-1:0];
    assign dst_hit  = (dst == i_self_mac) || (ACCEPT_BCAST && (dst == ETH_BCAST_MAC));
    assign type_hit = (etype == ETYPE_A) || (etype == ETYPE_B);
    assign accept   = dst_hit && type_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_wr      = 1'b0;
        buf_restart = 1'b0;
        rd_adv      = 1'b0;
        drop_c      = 1'b0;
        runt_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_xfer && rx_beat.sop) begin
                    buf_wr      = 1'b1;
                    buf_restart = 1'b1;
                    if (rx_beat.eop) begin
                        drop_c = 1'b1;
                        runt_c = 1'b1;
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                if (in_xfer) begin
                    buf_wr = 1'b1;
                    if (rx_beat.sop) begin
                        buf_restart = 1'b1;
                        if (rx_beat.eop) begin
                            drop_c  = 1'b1;
                            runt_c  = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (wr_idx == HDR_W3) begin
                        if (accept) begin
                            state_d = REPLAY;
                        end else begin
                            drop_c  = 1'b1;
                            state_d = rx_beat.eop ? IDLE : DROP;
                        end
                    end else if (rx_beat.eop) begin
                        drop_c  = 1'b1;
                        runt_c  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            REPLAY: begin
                if (i_tx_rdy) begin
                    rd_adv = 1'b1;
                    if (rd_idx == HDR_W3) begin
                        state_d = eop_flag ? IDLE : PASS;
                    end
                end
            end
            PASS, DROP: begin
                if (in_xfer && rx_beat.eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ingress ready stays low until the first clock after reset release
    always_comb begin
        o_rx_rdy  = 1'b0;
        o_tx_data = '0;
        o_tx_sop  = 1'b0;
        o_tx_eop  = 1'b0;
        o_tx_vld  = 1'b0;
        unique case (state_q)
            IDLE, HDR, DROP: begin
                o_rx_rdy = live_q;
            end
            REPLAY: begin
                o_tx_vld  = 1'b1;
                o_tx_data = rd_data;
                o_tx_sop  = (rd_idx == HDR_W0);
                o_tx_eop  = (rd_idx == HDR_W3) && eop_flag;
            end
            PASS: begin
                o_tx_data = rx_beat.data;
                o_tx_vld  = i_rx_vld;
                o_tx_eop  = rx_beat.eop;
                o_rx_rdy  = i_tx_rdy;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q     <= 1'b0;
            frm_drop_q <= 1'b0;
        end else begin
            live_q     <= 1'b1;
            frm_drop_q <= drop_c;
        end
    end

    assign o_frm_drop = frm_drop_q;

`ifdef ETH_RX_FILTER_STATS_EN
    logic [CNT_W-1:0] cnt_acc_q, cnt_drop_q, cnt_runt_q;
    logic             acc_c;

    assign acc_c = (state_q != REPLAY) && (state_d == REPLAY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_acc_q  <= '0;
            cnt_drop_q <= '0;
            cnt_runt_q <= '0;
        end else begin
            if (acc_c) begin
                cnt_acc_q <= sat_inc(cnt_acc_q);
            end
            if (drop_c) begin
                cnt_drop_q <= sat_inc(cnt_drop_q);
            end
            if (runt_c) begin
                cnt_runt_q <= sat_inc(cnt_runt_q);
            end
        end
    end

    assign o_cnt_acc  = cnt_acc_q;
    assign o_cnt_drop = cnt_drop_q;
    assign o_cnt_runt = cnt_runt_q;
`endif

endmodule

// File: tb/tb_eth_rx_filter.sv
// Self-checking bench for eth_rx_filter: frame table plus hand sequences, egress scoreboard.
module tb_eth_rx_filter;

    localparam logic [47:0] SELF_MAC = 48'h0022_36EC_0401;
    localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic [47:0] i_self_mac;
    logic [31:0] i_rx_data;
    logic        i_rx_sop, i_rx_eop, i_rx_vld;
    logic        o_rx_rdy;
    logic [31:0] o_tx_data;
    logic        o_tx_sop, o_tx_eop, o_tx_vld;
    logic        i_tx_rdy;
    logic        o_frm_drop;
`ifdef ETH_RX_FILTER_STATS_EN
    logic [15:0] o_cnt_acc, o_cnt_drop, o_cnt_runt;
`endif

    eth_rx_filter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_self_mac (i_self_mac),
        .i_rx_data  (i_rx_data),
        .i_rx_sop   (i_rx_sop),
        .i_rx_eop   (i_rx_eop),
        .i_rx_vld   (i_rx_vld),
        .o_rx_rdy   (o_rx_rdy),
        .o_tx_data  (o_tx_data),
        .o_tx_sop   (o_tx_sop),
        .o_tx_eop   (o_tx_eop),
        .o_tx_vld   (o_tx_vld),
        .i_tx_rdy   (i_tx_rdy),
`ifdef ETH_RX_FILTER_STATS_EN
        .o_cnt_acc  (o_cnt_acc),
        .o_cnt_drop (o_cnt_drop),
        .o_cnt_runt (o_cnt_runt),
`endif
        .o_frm_drop (o_frm_drop)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct {
        logic [47:0] dst;
        logic [15:0] etype;
        int          nwords;
        bit          tog;
        bit          fwd;
        int          drops;
        int          runts;
    } vec_t;

    beat_t exp_q[$];
    int    chk_cnt   = 0;
    int    pass_cnt  = 0;
    int    drop_seen = 0;
    bit    tog_mode  = 1'b0;
    int    exp_acc   = 0;
    int    exp_drop  = 0;
    int    exp_runt  = 0;
    vec_t  vecs[9];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Egress ready: constant high, or toggling every 2 clocks
    initial begin
        int tog_cnt;
        tog_cnt  = 0;
        i_tx_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tog_mode) begin
                tog_cnt++;
                if (tog_cnt >= 2) begin
                    tog_cnt  = 0;
                    i_tx_rdy = ~i_tx_rdy;
                end
            end else begin
                i_tx_rdy = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        beat_t prev;
        beat_t cur;
        beat_t e;
        bit    stall;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            cur = '{data: o_tx_data, sop: o_tx_sop, eop: o_tx_eop};
            if (o_frm_drop) drop_seen++;
            if (stall) chk("egress_hold", {o_tx_vld, cur}, {1'b1, prev});
            if (o_tx_vld && i_tx_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_egress_vld", 64'(o_tx_vld), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("egress_word", 64'(cur), 64'(e));
                end
            end
            stall = o_tx_vld && !i_tx_rdy;
            prev  = cur;
        end
    endtask

    task automatic drive_word(input logic [31:0] d, input logic s, input logic e);
        bit took;
        int n;
        i_rx_data = d;
        i_rx_sop  = s;
        i_rx_eop  = e;
        i_rx_vld  = 1'b1;
        took      = 1'b0;
        n         = 0;
        while (!took) begin
            @(negedge clk);
            took = o_rx_rdy;
            @(posedge clk);
            #1;
            n++;
            if (!took && n > 2000) begin
                chk("rx_rdy_timeout", 64'(o_rx_rdy), 64'd1);
                took = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int n,
                              input bit eop_last, input bit push);
        logic [47:0] src;
        logic [31:0] w;
        logic        s, e;
        src = {16'h0A0B, 32'($urandom())};
        for (int k = 0; k < n; k++) begin
            case (k)
                0:       w = {16'h0000, dst[47:32]};
                1:       w = dst[31:0];
                2:       w = src[47:16];
                3:       w = {src[15:0], et};
                default: w = 32'($urandom());
            endcase
            s = (k == 0);
            e = eop_last && (k == n - 1);
            if (push) exp_q.push_back('{data: w, sop: s, eop: e});
            drive_word(w, s, e);
        end
    endtask

    task automatic drain();
        int n;
        i_rx_vld = 1'b0;
        i_rx_sop = 1'b0;
        i_rx_eop = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_stats();
`ifdef ETH_RX_FILTER_STATS_EN
        chk("cnt_acc", 64'(o_cnt_acc), 64'(exp_acc));
        chk("cnt_drop", 64'(o_cnt_drop), 64'(exp_drop));
        chk("cnt_runt", 64'(o_cnt_runt), 64'(exp_runt));
`endif
    endtask

    initial begin
        int d0;
        rst_n      = 1'b0;
        i_self_mac = SELF_MAC;
        i_rx_data  = '0;
        i_rx_sop   = 1'b0;
        i_rx_eop   = 1'b0;
        i_rx_vld   = 1'b0;

        //           dst                 etype     n  tog fwd drops runts
        vecs[0] = '{BCAST,               16'h0806, 11, 0, 1, 0, 0};
        vecs[1] = '{SELF_MAC,            16'h0800, 25, 1, 1, 0, 0};
        vecs[2] = '{48'h0C54_A531_2485,  16'h0800, 43, 0, 0, 1, 0};
        vecs[3] = '{SELF_MAC,            16'h86DD,  9, 0, 0, 1, 0};
        vecs[4] = '{SELF_MAC,            16'h0800,  3, 0, 0, 1, 1};
        vecs[5] = '{SELF_MAC,            16'h0806,  4, 1, 1, 0, 0};
        vecs[6] = '{48'h0022_36EC_0400,  16'h0806,  4, 0, 0, 1, 0};
        vecs[7] = '{BCAST,               16'h86DD,  7, 0, 0, 1, 0};
        vecs[8] = '{SELF_MAC,            16'h0806,  2, 1, 0, 1, 1};

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rx_rdy", 64'(o_rx_rdy), 64'd0);
        chk("reset_tx_vld", 64'(o_tx_vld), 64'd0);
        chk("reset_tx_data", 64'(o_tx_data), 64'd0);
        chk("reset_frm_drop", 64'(o_frm_drop), 64'd0);
        rst_n = 1'b1;
        chk_stats();

        foreach (vecs[i]) begin
            d0       = drop_seen;
            tog_mode = vecs[i].tog;
            send_frame(vecs[i].dst, vecs[i].etype, vecs[i].nwords, 1'b1, vecs[i].fwd);
            drain();
            tog_mode = 1'b0;
            chk($sformatf("drop_pulses_v%0d", i), 64'(drop_seen - d0), 64'(vecs[i].drops));
            exp_acc  += int'(vecs[i].fwd);
            exp_drop += vecs[i].drops;
            exp_runt += vecs[i].runts;
            chk_stats();
        end

        // Rejected IPv6 frame immediately followed by an ARP frame
        d0 = drop_seen;
        send_frame(SELF_MAC, 16'h86DD, 8, 1'b1, 1'b0);
        send_frame(SELF_MAC, 16'h0806, 11, 1'b1, 1'b1);
        drain();
        chk("b2b_drop_pulses", 64'(drop_seen - d0), 64'd1);
        exp_acc++;
        exp_drop++;
        chk_stats();

        // sop inside the header restarts capture without a drop
        d0 = drop_seen;
        send_frame(SELF_MAC, 16'h0800, 2, 1'b0, 1'b0);
        send_frame(BCAST, 16'h0806, 6, 1'b1, 1'b1);
        drain();
        chk("restart_drop_pulses", 64'(drop_seen - d0), 64'd0);
        exp_acc++;
        chk_stats();

        // Reset pulse in PASS: outputs clear at once, the frame tail is discarded
        d0 = drop_seen;
        begin
            logic [31:0] tail[13];
            send_frame(SELF_MAC, 16'h0800, 12, 1'b0, 1'b1);
            for (int k = 0; k < 13; k++) tail[k] = 32'($urandom());
            i_rx_data = tail[0];
            i_rx_vld  = 1'b1;
            rst_n     = 1'b0;
            #1;
            chk("midrst_tx_vld", 64'(o_tx_vld), 64'd0);
            chk("midrst_rx_rdy", 64'(o_rx_rdy), 64'd0);
            chk("midrst_tx_data", 64'(o_tx_data), 64'd0);
            chk("midrst_tx_eop", 64'(o_tx_eop), 64'd0);
            exp_q.delete();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            for (int k = 0; k < 13; k++) drive_word(tail[k], 1'b0, (k == 12));
        end
        drain();
        chk("midrst_tail_drops", 64'(drop_seen - d0), 64'd0);
        exp_acc  = 0;
        exp_drop = 0;
        exp_runt = 0;
        chk_stats();

        tog_mode = 1'b1;
        send_frame(SELF_MAC, 16'h0800, 25, 1'b1, 1'b1);
        drain();
        tog_mode = 1'b0;
        exp_acc++;
        chk_stats();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
